// File: rtl/cpu_mc.sv
// Multi-cycle memory-to-memory CPU on a single synchronous RAM port.
// Three-operand ADD/SUB/MUL/MOV with optional indirection, IN/OUT handshakes and STOP.
module cpu_mc #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] PC_START = ADDR_WIDTH'(8),
  parameter logic [ADDR_WIDTH-1:0] SP_START = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp
);

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_OPY, S_OPYI, S_OPZ, S_OPZI, S_CONST,
    S_IN_WAIT, S_DST, S_DSTI, S_WRITE, S_OUTR, S_OUTW, S_HALT
  } state_e;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_STOP = 4'hF;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, sp_q, sp_d, tgt_q, tgt_d;
  logic [15:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic                  ld_a_q, ld_a_d, ld_b_q, ld_b_d;
  logic                  out_valid_q, out_valid_d, in_ready_q, in_ready_d, halted_q, halted_d;

  logic [3:0]            op;
  logic                  xi, yi, zi, arith;
  logic [ADDR_WIDTH-1:0] xa, ya, za, ptr;
  logic [DATA_WIDTH-1:0] result;

  function automatic logic [ADDR_WIDTH-1:0] ext3(input logic [2:0] f);
    return {{(ADDR_WIDTH-3){1'b0}}, f};
  endfunction

  assign op    = ir_q[15:12];
  assign xi    = ir_q[11];
  assign yi    = ir_q[7];
  assign zi    = ir_q[3];
  assign xa    = ext3(ir_q[10:8]);
  assign ya    = ext3(ir_q[6:4]);
  assign za    = ext3(ir_q[2:0]);
  assign arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  // Indirect pointers are whatever the previous read returned, truncated to an address.
  assign ptr   = mem_in[ADDR_WIDTH-1:0];

  always_comb begin
    case (op)
      OP_ADD:  result = a_q + b_q;
      OP_SUB:  result = a_q - b_q;
      OP_MUL:  result = a_q * b_q;
      default: result = a_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    tgt_d       = tgt_q;
    out_d       = out_q;
    ld_a_d      = 1'b0;
    ld_b_d      = 1'b0;
    out_valid_d = 1'b0;
    in_ready_d  = in_ready_q;
    halted_d    = halted_q;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    // Operand reads land one cycle after issue, whatever state we are in by then.
    if (ld_a_q) a_d = mem_in;
    if (ld_b_q) b_d = mem_in;
    case (state_q)
      S_START: begin
        pc_d    = PC_START;
        sp_d    = SP_START;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_addr = pc_q;
        pc_d     = pc_q + 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ir_d = mem_in[15:0];
        case (mem_in[15:12])
          OP_MOV: begin
            if (mem_in[3:0] == 4'b0000) state_d = S_OPY;
            else if (mem_in[3:0] == 4'b1000) begin
              mem_addr = pc_q;
              pc_d     = pc_q + 1'b1;
              state_d  = S_CONST;
            end else state_d = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_MUL: state_d = S_OPY;
          OP_IN: begin
            in_ready_d = 1'b1;
            state_d    = S_IN_WAIT;
          end
          OP_OUT: state_d = S_DST;
          OP_STOP: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_OPY: begin
        mem_addr = ya;
        if (yi) state_d = S_OPYI;
        else begin
          ld_a_d  = 1'b1;
          state_d = arith ? S_OPZ : S_DST;
        end
      end
      S_OPYI: begin
        mem_addr = ptr;
        ld_a_d   = 1'b1;
        state_d  = arith ? S_OPZ : S_DST;
      end
      S_OPZ: begin
        mem_addr = za;
        if (zi) state_d = S_OPZI;
        else begin
          ld_b_d  = 1'b1;
          state_d = S_DST;
        end
      end
      S_OPZI: begin
        mem_addr = ptr;
        ld_b_d   = 1'b1;
        state_d  = S_DST;
      end
      S_CONST: begin
        a_d     = mem_in;
        state_d = S_DST;
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          a_d        = in;
          in_ready_d = 1'b0;
          state_d    = S_DST;
        end
      end
      S_DST: begin
        if (xi) begin
          mem_addr = xa;
          state_d  = S_DSTI;
        end else begin
          tgt_d   = xa;
          state_d = (op == OP_OUT) ? S_OUTR : S_WRITE;
        end
      end
      S_DSTI: begin
        tgt_d   = ptr;
        state_d = (op == OP_OUT) ? S_OUTR : S_WRITE;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = tgt_q;
        mem_data = result;
        state_d  = S_FETCH;
      end
      S_OUTR: begin
        mem_addr = tgt_q;
        state_d  = S_OUTW;
      end
      S_OUTW: begin
        out_d       = mem_in;
        out_valid_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_START;
      pc_q        <= '0;
      sp_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tgt_q       <= '0;
      out_q       <= '0;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tgt_q       <= tgt_d;
      out_q       <= out_d;
      ld_a_q      <= ld_a_d;
      ld_b_q      <= ld_b_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      halted_q    <= halted_d;
    end
  end

  assign pc        = pc_q;
  assign sp        = sp_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboarded bench for cpu_mc: a behavioural sync RAM, expected writes/outputs queued
// as each program is loaded and popped when the CPU writes memory or pulses out_valid.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_in = '0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] in_d = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        halted;
  logic [5:0]  pc;
  logic [5:0]  sp;

  cpu_mc dut (
    .clk(clk), .rst_n(rst_n), .mem_in(mem_in), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .halted(halted), .pc(pc), .sp(sp)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  always @(posedge clk) begin
    mem_in <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_data;
  end

  typedef struct {
    bit          is_out;
    logic [5:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, we_cyc = 0, out_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      we_cyc = cyc;
      if (q.size() == 0) chk("sb_underflow_wr", q.size(), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_kind", e.is_out, 0);
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_data, e.data);
      end
    end
    if (rst_n && out_valid) begin
      out_cnt++;
      if (q.size() == 0) chk("sb_underflow_out", q.size(), 1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_kind", e.is_out, 1);
        chk("out_data", out, e.data);
      end
    end
  end

  task automatic push(input bit is_out, input logic [5:0] a, input logic [15:0] d);
    exp_t e;
    e.is_out = is_out; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic rst_cpu();
    rst_n = 1'b0; in_valid = 1'b0; in_d = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) mem[i] = '0;
    q.delete();
    out_cnt = 0;
  endtask

  // Release reset; one cycle later START has loaded pc/sp and FETCH is in progress.
  task automatic go(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_pc_start"}, pc, 8);
    chk({tag, "_sp_start"}, sp, 63);
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_sb_empty"}, q.size(), 0);
  endtask

  initial begin
    int cnt, we_seen, pc_moved;
    logic [5:0] pc_hold;

    // Reset values
    rst_cpu();
    chk("rst_pc_sp", {pc, sp}, 0);
    chk("rst_outs", {out, out_valid, in_ready, halted, mem_we}, 0);

    // IN with in_valid arriving on the 4th in_ready cycle
    mem[8] = 16'h7100; mem[9] = 16'hF000;
    push(0, 6'd1, 16'h00AB);
    go("in");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready) begin
        cnt++;
        if (cnt == 4) begin in_valid = 1'b1; in_d = 16'h00AB; end
      end else if (cnt > 0) break;
    end
    in_valid = 1'b0;
    chk("in_ready_cycles", cnt, 4);
    run_to_halt("in");
    chk("in_latency", we_cyc, 8);
    chk("in_mem1", mem[1], 16'h00AB);
    chk("in_pc_halt", pc, 10);

    // ADD direct
    rst_cpu();
    mem[1] = 16'd5; mem[2] = 16'd7; mem[8] = 16'h1312; mem[9] = 16'hF000;
    push(0, 6'd3, 16'h000C);
    go("add");
    run_to_halt("add");
    chk("add_latency", we_cyc, 6);

    // SUB wrap-around
    rst_cpu();
    mem[1] = 16'd1; mem[2] = 16'd2; mem[8] = 16'h2312; mem[9] = 16'hF000;
    push(0, 6'd3, 16'hFFFF);
    go("sub");
    run_to_halt("sub");

    // MUL keeps only the low word: 0x0300*0x0101 = 0x30300
    rst_cpu();
    mem[1] = 16'h0300; mem[2] = 16'h0101; mem[8] = 16'h3312; mem[9] = 16'hF000;
    push(0, 6'd3, 16'h0300);
    go("mul");
    run_to_halt("mul");

    // MOV *4,*5 with a pointer wider than the address (0xFFC3 -> 3)
    rst_cpu();
    mem[3] = 16'h1234; mem[4] = 16'd6; mem[5] = 16'hFFC3;
    mem[8] = 16'h0CD0; mem[9] = 16'hF000;
    push(0, 6'd6, 16'h1234);
    go("movi");
    run_to_halt("movi");
    chk("movi_latency", we_cyc, 7);
    chk("movi_untouched", {mem[3], mem[4], mem[5]}, {16'h1234, 16'd6, 16'hFFC3});

    // MOV constant
    rst_cpu();
    mem[8] = 16'h0108; mem[9] = 16'hBEEF; mem[10] = 16'hF000;
    push(0, 6'd1, 16'hBEEF);
    go("movc");
    run_to_halt("movc");
    chk("movc_latency", we_cyc, 5);
    chk("movc_pc_halt", pc, 11);

    // OUT then STOP; halted CPU stays silent
    rst_cpu();
    mem[2] = 16'h0042; mem[8] = 16'h8200; mem[9] = 16'hF000;
    push(1, 6'd0, 16'h0042);
    go("out");
    run_to_halt("out");
    chk("out_pulses", out_cnt, 1);
    chk("out_value", out, 16'h0042);
    chk("halt_pc", pc, 10);
    we_seen = 0; pc_moved = 0; pc_hold = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (pc != pc_hold) pc_moved++;
    end
    chk("halt_no_we", we_seen, 0);
    chk("halt_pc_frozen", pc_moved, 0);
    chk("halt_still", halted, 1);

    // Reset asserted inside the WRITE cycle of an ADD
    rst_cpu();
    mem[1] = 16'd5; mem[2] = 16'd7; mem[3] = 16'h5555; mem[8] = 16'h1312; mem[9] = 16'hF000;
    go("rstw");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rstw_in_write", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", mem_we, 0);
    chk("rstw_outs", {pc, sp, out, out_valid, in_ready, halted}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_no_write", mem[3], 16'h5555);
    push(0, 6'd3, 16'h000C);
    go("rstw_restart");
    run_to_halt("rstw_restart");
    chk("rstw_mem3", mem[3], 16'h000C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
